// File: rtl/stepper_axis_driver.sv
// Per-axis stepper pulse generator: a phase accumulator requests steps, and a small FSM
// shapes STEP/DIR with setup and pulse timing while tracking a limited absolute position.
module stepper_axis_driver #(
  parameter int ACC_W         = 24,
  parameter int SPEED_W       = 16,
  parameter int PULSE_CYC     = 100,
  parameter int DIR_SETUP_CYC = 50,
  parameter int POS_MIN       = -100000,
  parameter int POS_MAX       = 100000
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        enable,
  input  logic [31:0] speed,
  input  logic [31:0] direction,
  input  logic        zero_pos,
  output logic        step_out,
  output logic        dir_out,
  output logic [31:0] position,
  output logic        busy,
  output logic        at_limit
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} StepState;

  localparam int CNT_MAX = (PULSE_CYC > DIR_SETUP_CYC) ? PULSE_CYC : DIR_SETUP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP_CYC - 1);

  StepState         state;
  StepState         nextState;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             pending;
  logic [ACC_W:0]   speedExt;
  logic [ACC_W:0]   accSum;
  logic             carry;
  logic             reqDir;
  logic signed [31:0] posSigned;
  logic             limitHit;
  logic             decide;
  logic             enterHigh;
  logic             enterSetup;

  if (SPEED_W < 32) begin : genUnusedSpeed
    logic unusedSpeedBits;
    assign unusedSpeedBits = ^speed[31:SPEED_W];
  end

  assign speedExt   = (ACC_W + 1)'(speed[SPEED_W-1:0]);
  assign accSum     = {1'b0, acc} + speedExt;
  assign carry      = accSum[ACC_W];
  assign reqDir     = |direction;
  assign posSigned  = position;
  assign limitHit   = reqDir ? (posSigned >= POS_MAX) : (posSigned <= POS_MIN);
  assign decide     = (state == IDLE) && pending;
  assign enterHigh  = (state != HIGH) && (nextState == HIGH);
  assign enterSetup = (state == IDLE) && (nextState == SETUP);

  // State register
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) state <= IDLE;
    else            state <= nextState;
  end

  // Next-state logic; the IDLE decision consumes one pending request
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (pending && !limitHit) nextState = (reqDir != dir_out) ? SETUP : HIGH;
      end
      SETUP:   if (cnt == '0) nextState = HIGH;
      HIGH:    if (cnt == '0) nextState = LOW;
      LOW:     if (cnt == '0) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    step_out = (state == HIGH);
    busy     = (state != IDLE);
  end

  // Dwell counter reloads on every state change and counts down to zero
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      cnt <= '0;
    end else if (nextState != state) begin
      case (nextState)
        SETUP:     cnt <= SETUP_LOAD;
        HIGH, LOW: cnt <= PULSE_LOAD;
        default:   cnt <= '0;
      endcase
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A carry arriving while a request is already pending (or being consumed) is dropped
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      acc     <= '0;
      pending <= 1'b0;
    end else if (!enable) begin
      acc     <= '0;
      pending <= 1'b0;
    end else begin
      acc <= accSum[ACC_W-1:0];
      if (decide)     pending <= 1'b0;
      else if (carry) pending <= 1'b1;
    end
  end

  // Direction, position and limit flag; zero_pos overrides a simultaneous step
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      dir_out  <= 1'b0;
      position <= '0;
      at_limit <= 1'b0;
    end else begin
      if (enterSetup) dir_out <= reqDir;
      if (zero_pos) begin
        position <= '0;
      end else if (enterHigh) begin
        position <= dir_out ? position + 32'd1 : position - 32'd1;
      end
      if (zero_pos)                at_limit <= 1'b0;
      else if (decide && limitHit) at_limit <= 1'b1;
      else if (enterHigh)          at_limit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stepper_axis_driver.sv
// Scoreboard bench for stepper_axis_driver: stimulus queues the expected STEP events,
// a negedge monitor checks each STEP rise for position, direction and timing.
module tb_stepper_axis_driver;

  typedef struct {
    int   pos;
    logic dir;
    int   gap;
    int   setup;
  } StepExp;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        enable;
  logic [31:0] speed;
  logic [31:0] direction;
  logic        zero_pos;
  logic        step_out;
  logic        dir_out;
  logic [31:0] position;
  logic        busy;
  logic        at_limit;

  StepExp sbQueue[$];
  int     vectors     = 0;
  int     miscompares = 0;
  int     cycle       = 0;

  stepper_axis_driver #(
    .ACC_W(8), .SPEED_W(8), .PULSE_CYC(2), .DIR_SETUP_CYC(3), .POS_MIN(-5), .POS_MAX(5)
  ) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .enable(enable), .speed(speed),
    .direction(direction), .zero_pos(zero_pos), .step_out(step_out), .dir_out(dir_out),
    .position(position), .busy(busy), .at_limit(at_limit)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle = cycle + 1;

  // Monitor: every STEP rise pops one expected event; falls and DIR changes are timing-checked
  initial begin : monitor
    logic prevStep = 1'b0;
    logic prevDir  = 1'b0;
    int   lastRise = 0;
    int   lastDir  = 0;
    StepExp e;
    forever begin
      @(negedge clock);
      if (ctrl_reset) begin
        prevStep = 1'b0;
        prevDir  = 1'b0;
      end else begin
        if (dir_out != prevDir) begin
          vectors++;
          if (step_out || prevStep) begin
            miscompares++;
            $display("[TB] FAIL dirDuringStep at cycle %0d: dir_out changed with step_out=%0b, required step_out=0", cycle, step_out);
          end
          lastDir = cycle;
        end
        if (step_out && !prevStep) begin
          vectors++;
          if (sbQueue.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpectedStep at cycle %0d: got step with position=%0d, required no step", cycle, $signed(position));
          end else begin
            e = sbQueue.pop_front();
            if ($signed(position) != e.pos || dir_out != e.dir ||
                (e.gap != 0 && cycle - lastRise != e.gap) ||
                (e.setup != 0 && cycle - lastDir != e.setup)) begin
              miscompares++;
              $display("[TB] FAIL step at cycle %0d: got pos=%0d dir=%0b gap=%0d setup=%0d, required pos=%0d dir=%0b gap=%0d setup=%0d (0=any)",
                       cycle, $signed(position), dir_out, cycle - lastRise, cycle - lastDir, e.pos, e.dir, e.gap, e.setup);
            end
          end
          lastRise = cycle;
        end
        if (!step_out && prevStep) begin
          vectors++;
          if (cycle - lastRise != 2) begin
            miscompares++;
            $display("[TB] FAIL highWidth at cycle %0d: got %0d cycles, required 2", cycle, cycle - lastRise);
          end
        end
        prevStep = step_out;
        prevDir  = dir_out;
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] spd, input logic [31:0] dirVal);
    enable    = en;
    speed     = spd;
    direction = dirVal;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, $signed(actual), $signed(expected));
    end
  endtask

  task automatic pushStep(input int pos, input logic dir, input int gap, input int setup);
    StepExp e;
    e.pos = pos; e.dir = dir; e.gap = gap; e.setup = setup;
    sbQueue.push_back(e);
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n = 0;
    while (sbQueue.size() != 0 && n < limit) begin
      waitCycles(1);
      n++;
    end
    if (sbQueue.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: %0d expected steps missing after %0d cycles, required 0", name, sbQueue.size(), limit);
      sbQueue.delete();
    end
  endtask

  initial begin : stimulus
    ctrl_reset = 1'b1;
    zero_pos   = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0);
    #2;
    checkOutput("resetStep", 32'(step_out), 32'd0);
    checkOutput("resetDir", 32'(dir_out), 32'd0);
    checkOutput("resetPos", position, 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetLimit", 32'(at_limit), 32'd0);
    waitCycles(2);
    ctrl_reset = 1'b0;

    $display("[TB] steady forward to upper limit");
    pushStep(1, 1'b1, 0, 3);
    pushStep(2, 1'b1, 5, 0);
    pushStep(3, 1'b1, 8, 0);
    pushStep(4, 1'b1, 8, 0);
    pushStep(5, 1'b1, 8, 0);
    applyStimulus(1'b1, 32'd32, 32'd1);
    waitDrain("forward", 80);
    waitCycles(12);
    checkOutput("upperLimitFlag", 32'(at_limit), 32'd1);
    checkOutput("upperLimitPos", position, 32'd5);
    checkOutput("upperLimitBusy", 32'(busy), 32'd0);

    $display("[TB] zero_pos and resume");
    zero_pos = 1'b1;
    waitCycles(1);
    zero_pos = 1'b0;
    checkOutput("zeroPos", position, 32'd0);
    checkOutput("zeroLimitFlag", 32'(at_limit), 32'd0);
    pushStep(1, 1'b1, 0, 0);
    pushStep(2, 1'b1, 8, 0);
    waitDrain("resume", 40);

    $display("[TB] reversal to lower limit");
    direction = 32'd0;
    pushStep(1, 1'b0, 11, 3);
    pushStep(0, 1'b0, 5, 0);
    for (int p = -1; p >= -5; p--) pushStep(p, 1'b0, 8, 0);
    waitDrain("reverse", 100);
    waitCycles(12);
    checkOutput("lowerLimitFlag", 32'(at_limit), 32'd1);
    checkOutput("lowerLimitPos", position, 32'(-5));

    $display("[TB] overrun at full speed");
    pushStep(-4, 1'b1, 0, 3);
    pushStep(-3, 1'b1, 5, 0);
    pushStep(-2, 1'b1, 5, 0);
    pushStep(-1, 1'b1, 5, 0);
    applyStimulus(1'b1, 32'd255, 32'd1);
    waitDrain("overrun", 60);

    $display("[TB] enable drop mid pulse");
    applyStimulus(1'b0, 32'd255, 32'd1);
    checkOutput("dropInHigh", 32'(step_out), 32'd1);
    waitCycles(20);
    checkOutput("dropBusy", 32'(busy), 32'd0);
    checkOutput("dropPos", position, 32'(-1));
    applyStimulus(1'b1, 32'd0, 32'd1);
    waitCycles(20);
    checkOutput("zeroSpeedBusy", 32'(busy), 32'd0);
    checkOutput("zeroSpeedPos", position, 32'(-1));

    $display("[TB] reset mid pulse");
    pushStep(0, 1'b1, 0, 0);
    pushStep(1, 1'b1, 5, 0);
    applyStimulus(1'b1, 32'd255, 32'd1);
    waitDrain("preReset", 40);
    checkOutput("preResetStep", 32'(step_out), 32'd1);
    checkOutput("preResetPos", position, 32'd1);
    #1 ctrl_reset = 1'b1;
    #1;
    checkOutput("asyncResetStep", 32'(step_out), 32'd0);
    checkOutput("asyncResetPos", position, 32'd0);
    checkOutput("asyncResetDir", 32'(dir_out), 32'd0);
    checkOutput("asyncResetBusy", 32'(busy), 32'd0);
    checkOutput("asyncResetLimit", 32'(at_limit), 32'd0);
    waitCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
